// File: rtl/scan_bridge_pkg.sv
// rtl/scan_bridge_pkg.sv - shared types and frame field offsets for the scan bridge
package scan_bridge_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_BURST = 2'd3
    } op_e;

    typedef enum logic {
        TGT_SRAM = 1'b0,
        TGT_CTR  = 1'b1
    } tgt_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    // Frame layout MSB->LSB: op[1:0], tgt, id_sel, lane, addr, data
    function automatic int frame_width(int lane_w, int addr_w, int data_w);
        return 4 + lane_w + addr_w + data_w;
    endfunction

    function automatic int addr_lsb(int data_w);
        return data_w;
    endfunction

    function automatic int lane_lsb(int addr_w, int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int idsel_bit(int lane_w, int addr_w, int data_w);
        return lane_w + addr_w + data_w;
    endfunction

    function automatic int tgt_bit(int lane_w, int addr_w, int data_w);
        return lane_w + addr_w + data_w + 1;
    endfunction

    function automatic int op_lsb(int lane_w, int addr_w, int data_w);
        return lane_w + addr_w + data_w + 2;
    endfunction

endpackage

// File: rtl/scan_pad_sync.sv
// rtl/scan_pad_sync.sv - two-flop pad synchroniser with rising-edge pulse
module scan_pad_sync (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic rise
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], pad};
    end

    // sync_q[2] is only an edge-detect history stage
    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/scan_bridge_param.sv
// rtl/scan_bridge_param.sv - scan-chain frames to SRAM / control-register transactions
module scan_bridge_param
    import scan_bridge_pkg::*;
#(
    parameter  int DATA_W  = 16,
    parameter  int ADDR_W  = 11,
    parameter  int LANES   = 16,
    parameter  int CTR_NUM = 4,
    parameter  int TIMEOUT = 64,
    localparam int LANE_W  = $clog2(LANES),
    localparam int CSEL_W  = (CTR_NUM > 1) ? $clog2(CTR_NUM) : 1,
    localparam int FRAME_W = frame_width(LANE_W, ADDR_W, DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_phi,
    input  logic              scan_phi_bar,
    input  logic              scan_data_in,
    output logic              scan_data_out,
    input  logic              scan_load_chip,
    input  logic              scan_load_chain,
    output logic              sram_ren,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ready,
    output logic              ctr_ren,
    output logic              ctr_wen,
    output logic [CSEL_W-1:0] ctr_sel,
    output logic [DATA_W-1:0] ctr_wdata,
    input  logic [DATA_W-1:0] ctr_rdata,
    input  logic              ctr_ready,
    output logic [LANE_W-1:0] lane_id,
    output logic              id_sel
);

    localparam int CNT_W     = $clog2(TIMEOUT + 1);
    localparam int ADDR_LSB  = addr_lsb(DATA_W);
    localparam int LANE_LSB  = lane_lsb(ADDR_W, DATA_W);
    localparam int IDSEL_BIT = idsel_bit(LANE_W, ADDR_W, DATA_W);
    localparam int TGT_BIT   = tgt_bit(LANE_W, ADDR_W, DATA_W);
    localparam int OP_LSB    = op_lsb(LANE_W, ADDR_W, DATA_W);

    logic phi_rise, phi_bar_rise, chip_rise, chain_rise;

    scan_pad_sync u_sync_phi     (.clk(clk), .rst(rst), .pad(scan_phi),        .rise(phi_rise));
    scan_pad_sync u_sync_phi_bar (.clk(clk), .rst(rst), .pad(scan_phi_bar),    .rise(phi_bar_rise));
    scan_pad_sync u_sync_chip    (.clk(clk), .rst(rst), .pad(scan_load_chip),  .rise(chip_rise));
    scan_pad_sync u_sync_chain   (.clk(clk), .rst(rst), .pad(scan_load_chain), .rise(chain_rise));

    logic [FRAME_W-1:0] chain;
    state_e             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               err_to, overrun, burst_active, cur_read;
    tgt_e               cur_tgt;
    logic [ADDR_W-1:0]  burst_ptr, last_addr, issue_addr;
    logic [DATA_W-1:0]  rd_buf;

    op_e               f_op;
    tgt_e              f_tgt;
    logic              f_id_sel, is_burst, ready_sel;
    logic [LANE_W-1:0] f_lane;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_data;

    assign f_op     = op_e'(chain[OP_LSB +: 2]);
    assign f_tgt    = tgt_e'(chain[TGT_BIT]);
    assign f_id_sel = chain[IDSEL_BIT];
    assign f_lane   = chain[LANE_LSB +: LANE_W];
    assign f_addr   = chain[ADDR_LSB +: ADDR_W];
    assign f_data   = chain[DATA_W-1:0];

    // A burst aimed at the control registers degrades to a plain write
    assign is_burst   = (f_op == OP_BURST) && (f_tgt == TGT_SRAM);
    assign issue_addr = (is_burst && burst_active) ? burst_ptr + ADDR_W'(1) : f_addr;
    assign ready_sel  = (cur_tgt == TGT_CTR) ? ctr_ready : sram_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain         <= '0;
            scan_data_out <= 1'b0;
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            err_to        <= 1'b0;
            overrun       <= 1'b0;
            burst_active  <= 1'b0;
            burst_ptr     <= '0;
            last_addr     <= '0;
            rd_buf        <= '0;
            cur_read      <= 1'b0;
            cur_tgt       <= TGT_SRAM;
            sram_ren      <= 1'b0;
            sram_wen      <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            ctr_ren       <= 1'b0;
            ctr_wen       <= 1'b0;
            ctr_sel       <= '0;
            ctr_wdata     <= '0;
            lane_id       <= '0;
            id_sel        <= 1'b0;
        end else begin
            if (phi_bar_rise) scan_data_out <= chain[FRAME_W-1];

            // Capture uses pre-command status; a same-cycle command still decodes the old chain
            if (chain_rise) begin
                chain   <= {1'b0, state == ST_REQ, err_to, overrun, lane_id, last_addr, rd_buf};
                err_to  <= 1'b0;
                overrun <= 1'b0;
            end else if (phi_rise) begin
                chain <= {chain[FRAME_W-2:0], scan_data_in};
            end

            case (state)
                ST_IDLE: begin
                    if (chip_rise) begin
                        lane_id      <= f_lane;
                        id_sel       <= f_id_sel;
                        burst_active <= is_burst;
                        if (f_op != OP_NOP) begin
                            state     <= ST_REQ;
                            wait_cnt  <= '0;
                            cur_tgt   <= f_tgt;
                            cur_read  <= (f_op == OP_READ);
                            last_addr <= issue_addr;
                            if (is_burst) burst_ptr <= issue_addr;
                            if (f_tgt == TGT_SRAM) begin
                                sram_addr  <= issue_addr;
                                sram_wdata <= f_data;
                                sram_ren   <= (f_op == OP_READ);
                                sram_wen   <= (f_op != OP_READ);
                            end else begin
                                ctr_sel   <= f_addr[CSEL_W-1:0];
                                ctr_wdata <= f_data;
                                ctr_ren   <= (f_op == OP_READ);
                                ctr_wen   <= (f_op != OP_READ);
                            end
                        end
                    end
                end
                ST_REQ: begin
                    if (chip_rise) overrun <= 1'b1;
                    if (ready_sel) begin
                        if (cur_read) rd_buf <= (cur_tgt == TGT_CTR) ? ctr_rdata : sram_rdata;
                        {sram_ren, sram_wen, ctr_ren, ctr_wen} <= '0;
                        state <= ST_IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        {sram_ren, sram_wen, ctr_ren, ctr_wen} <= '0;
                        err_to <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/scan_bridge_param.md
Name: scan_bridge_param

Overview:
- Parametrised successor to the fixed-width scan-chain bridge; converts serial scan frames into SRAM or control-register transactions and returns read data/status through the same chain.
- Generalised data/address width, lane count, number of control registers, burst auto-increment writes, access timeout and sticky status.
- Sits between the chip scan pads and the SIMD engine's SRAM and control-register ports.
- Single clock domain: scan pad inputs are asynchronous and are synchronised internally.

Parameters:
- DATA_W, 16, SRAM/ctr data width.
- ADDR_W, 11, SRAM word address width.
- LANES, 16, SIMD lane count; LANE_W = $clog2(LANES).
- CTR_NUM, 4, number of control registers; CSEL_W = $clog2(CTR_NUM), minimum 1.
- TIMEOUT, 64, clk cycles to wait for ready before aborting.
- FRAME_W, derived = 2+1+1+LANE_W+ADDR_W+DATA_W; not overridable.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- scan_phi, scan_phi_bar  in  1 each  two-phase scan clocks (async pads)
- scan_data_in  in  1  serial in
- scan_data_out  out  1  serial out
- scan_load_chip  in  1  apply chain frame as command (async pad)
- scan_load_chain  in  1  capture response into chain (async pad)
- sram_ren, sram_wen  out  1  SRAM strobes
- sram_addr  out  ADDR_W
- sram_wdata  out  DATA_W
- sram_rdata  in  DATA_W
- sram_ready  in  1
- ctr_ren, ctr_wen  out  1
- ctr_sel  out  CSEL_W  register select (addr[CSEL_W-1:0])
- ctr_wdata  out  DATA_W
- ctr_rdata  in  DATA_W
- ctr_ready  in  1
- lane_id  out  LANE_W  lane of last issued command
- id_sel  out  1  instruction(1)/data(0) select of last issued command

Behaviour:
- Reset: all outputs 0, chain 0, FSM IDLE, status 0, burst pointer 0.
- Sync: scan_phi, scan_phi_bar, scan_load_chip and scan_load_chain each pass through a 2-FF synchroniser and rising-edge detect. Pads must be held at least 3 clk cycles per level.
- Shift: on phi rise, chain <= {chain[FRAME_W-2:0], scan_data_in}. On phi_bar rise, scan_data_out <= chain[FRAME_W-1].
- Frame MSB->LSB: op[1:0], tgt (0 = SRAM, 1 = ctr), id_sel, lane, addr, data.
- Op codes: 0 = NOP, 1 = WRITE, 2 = READ, 3 = BURST_WRITE.
- load_chip rise while IDLE:
  - Latch the frame and update lane_id/id_sel.
  - NOP: nothing further.
  - Otherwise go to REQ.
- BURST_WRITE:
  - First burst after any non-burst op uses frame addr and sets burst_active.
  - Subsequent bursts use ptr+1 and ignore the frame addr.
  - Address wraps 2^ADDR_W-1 -> 0.
  - Any non-burst op clears burst_active.
  - Burst with tgt = 1 behaves as WRITE and does not burst.
- FSM:
  - IDLE -> REQ on command.
  - REQ: the selected ren/wen is held high with addr/wdata stable, and stays high until ready.
  - ready seen -> IDLE; a READ latches rdata into rd_buf in the same cycle; ready in the first REQ cycle is legal (1-cycle access).
  - Wait counter reaches TIMEOUT -> drop strobe, set err_to, go IDLE.
- load_chip rise while not IDLE: command ignored, sticky overrun set.
- load_chain rise: chain <= {2'b00, err_to, overrun, lane_id, last_addr, rd_buf}, where busy (FSM != IDLE) replaces bit 0 of the 2'b00 field. err_to and overrun clear on that same cycle.
- Simultaneous load_chain and load_chip in one cycle:
  - Capture happens first with pre-command status.
  - The command then issues from the pre-capture chain contents.
- Shift edge coinciding with load_chain: load wins, shift lost. Protocol forbids this.
- Reset mid-transaction: strobes drop immediately (async); rd_buf cleared.

Decomposition:
- Package scan_bridge_pkg:
  - op_e enum (NOP/WRITE/READ/BURST_WRITE).
  - tgt_e enum.
  - state_e enum (IDLE/REQ).
  - Frame field offset localparams as functions of widths.
- Sub-module scan_pad_sync (2-FF sync plus rise detect), instantiated 4x.

Test Plan:
1. WRITE: shift op=1, tgt=0, addr=0x005, data=0xBEEF, then load_chip -> sram_wen high with addr 0x005 / wdata 0xBEEF until sram_ready; SRAM[5]=0xBEEF.
2. READ: read addr 0x005, load_chain, shift out -> rd_buf field 0xBEEF, last_addr 0x005, status bits 0.
3. Burst: BURST_WRITE addr 0x7FF data A, then two more bursts with data B, C -> SRAM[0x7FF]=A, SRAM[0]=B, SRAM[1]=C (wrap); a following WRITE to 0x010 uses 0x010.
4. Ctr: WRITE tgt=1, addr=2, data=0x1234, lane=9, id_sel=1 -> ctr_sel=2, ctr_wen, lane_id=9, id_sel=1; a READ returns 0x1234.
5. Timeout: hold ctr_ready=0 -> strobe drops after 64 cycles; captured frame has err_to=1; a second capture shows err_to=0.
6. Overrun: second load_chip during an outstanding access -> ignored, overrun=1 in the next capture. Async reset asserted mid-REQ -> all strobes 0 within the same cycle.
